// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and elaboration helpers for adder_pipelined
//
// Purpose: width constants for the per-stage handshake bits and the helper
// functions used to size the carry-split slices and reject illegal
// WIDTH/STAGES combinations at elaboration time.
package adder_pkg;

    // Each pipeline entry carries a single valid bit; the stall condition is
    // one bit shared by every register in the pipe.
    localparam int VALID_W = 1;
    localparam int STALL_W = 1;

    // Number of operand bits handled by each carry-split slice.
    function automatic int slice_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    // A legal configuration needs at least two bits and an exact split of
    // the operand into equal slices.
    function automatic bit params_legal(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational S-bit add/subtract slice of the carry-split adder
//
// Purpose: adds one S-bit slice of A and (B xor Sub) plus a carry-in.
// Ports:
//   a_i    [S-1:0]  operand A slice
//   b_i    [S-1:0]  operand B slice (inverted here when sub_i=1)
//   sub_i           1 = subtract
//   cin_i           carry into the slice LSB
//   sum_o  [S-1:0]  sum slice
//   cout_o          carry out of the slice MSB
//   cmsb_o          carry into the slice MSB (used for signed overflow)
module adder_slice
    import adder_pkg::*;
#(
    parameter int S = 4
) (
    input  logic [S-1:0] a_i,
    input  logic [S-1:0] b_i,
    input  logic         sub_i,
    input  logic         cin_i,
    output logic [S-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    logic [S-1:0] b_eff;
    logic [S:0]   total;

    always_comb begin
        b_eff  = b_i ^ {S{sub_i}};
        total  = {1'b0, a_i} + {1'b0, b_eff} + {{S{1'b0}}, cin_i};
        sum_o  = total[S-1:0];
        cout_o = total[S];
        // The MSB sum bit is a ^ b ^ carry-in, so the carry into the MSB can
        // be recovered without a separate (S-1)-bit adder; this also covers S=1.
        cmsb_o = total[S-1] ^ a_i[S-1] ^ b_eff[S-1];
    end

endmodule

// File: rtl/adder_pipelined.sv
// rtl/adder_pipelined.sv - pipelined carry-split two's-complement add/subtract unit
//
// Purpose: registered A+B / A-B with a valid/ready handshake on both sides.
// One input register stage followed by STAGES slice stages; the last slice
// stage is the output register.
// Ports:
//   Clk           system clock, rising edge
//   Rst           asynchronous active-high reset
//   in_valid      operand transaction offered
//   in_ready      operand accepted this cycle when in_valid is also high
//   A, B [W-1:0]  operands
//   Sub           0 = A+B, 1 = A-B (captured with the operands)
//   out_valid     output registers hold a result
//   out_ready     consumer takes the result this cycle
//   Sum_reg       registered sum modulo 2^WIDTH
//   Carry_reg     carry out of the MSB (not-borrow when subtracting)
//   Overflow_reg  signed overflow
module adder_pipelined
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum_reg,
    output logic             Carry_reg,
    output logic             Overflow_reg
);

    localparam int S = slice_width(WIDTH, STAGES);

    generate
        if (!params_legal(WIDTH, STAGES)) begin : g_param_check
            $error("adder_pipelined: WIDTH must be >= 2 and an exact multiple of STAGES");
        end
    endgenerate

    // Pipeline entry k feeds slice k; entry STAGES is the output register.
    // acc_q holds the not-yet-added upper bits of A together with the sum
    // bits already produced below them, so each slice overwrites its own
    // field and the final entry is the complete sum.
    logic [VALID_W-1:0] valid_q [0:STAGES];
    logic [VALID_W-1:0] valid_d [0:STAGES];
    logic [WIDTH-1:0]   acc_q   [0:STAGES];
    logic [WIDTH-1:0]   acc_d   [0:STAGES];
    logic               carry_q [0:STAGES];
    logic               carry_d [0:STAGES];
    logic [WIDTH-1:0]   b_q     [0:STAGES-1];
    logic [WIDTH-1:0]   b_d     [0:STAGES-1];
    logic               sub_q   [0:STAGES-1];
    logic               sub_d   [0:STAGES-1];
    logic               ovf_q;
    logic               ovf_d;

    logic [S-1:0]       slice_sum  [0:STAGES-1];
    logic               slice_cout [0:STAGES-1];
    logic               slice_cmsb [0:STAGES-1];

    logic [STALL_W-1:0] stall;

    // A held result blocks the whole pipe, bubbles included, so results keep
    // their order and nothing is overwritten.
    assign stall    = {STALL_W{valid_q[STAGES][0] & ~out_ready}};
    assign in_ready = ~stall[0] & ~Rst;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            adder_slice #(
                .S (S)
            ) u_slice (
                .a_i    (acc_q[k][k*S +: S]),
                .b_i    (b_q[k][k*S +: S]),
                .sub_i  (sub_q[k]),
                .cin_i  (carry_q[k]),
                .sum_o  (slice_sum[k]),
                .cout_o (slice_cout[k]),
                .cmsb_o (slice_cmsb[k])
            );
        end
    endgenerate

    always_comb begin
        // Input stage: the carry into slice 0 is Sub itself, completing the
        // two's-complement negation of B.
        valid_d[0] = {VALID_W{in_valid & in_ready}};
        acc_d[0]   = A;
        carry_d[0] = Sub;
        b_d[0]     = B;
        sub_d[0]   = Sub;

        for (int k = 0; k < STAGES; k++) begin
            valid_d[k+1]             = valid_q[k];
            acc_d[k+1]               = acc_q[k];
            acc_d[k+1][k*S +: S]     = slice_sum[k];
            carry_d[k+1]             = slice_cout[k];
        end

        for (int k = 1; k < STAGES; k++) begin
            b_d[k]   = b_q[k-1];
            sub_d[k] = sub_q[k-1];
        end

        ovf_d = slice_cmsb[STAGES-1] ^ slice_cout[STAGES-1];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                valid_q[k] <= '0;
                acc_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                b_q[k]   <= '0;
                sub_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (!stall[0]) begin
            for (int k = 0; k <= STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                acc_q[k]   <= acc_d[k];
                carry_q[k] <= carry_d[k];
            end
            for (int k = 0; k < STAGES; k++) begin
                b_q[k]   <= b_d[k];
                sub_q[k] <= sub_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid    = valid_q[STAGES][0];
    assign Sum_reg      = acc_q[STAGES];
    assign Carry_reg    = carry_q[STAGES];
    assign Overflow_reg = ovf_q;

endmodule

// File: tb/tb_adder_pipelined.sv
// tb/tb_adder_pipelined.sv - self-checking bench for adder_pipelined
module tb_adder_pipelined;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance, WIDTH=8 STAGES=2
    logic       in_valid, in_ready, Sub, out_valid, out_ready, Carry_reg, Overflow_reg;
    logic [7:0] A, B, Sum_reg;

    adder_pipelined #(.WIDTH(8), .STAGES(2)) u_dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .A            (A),
        .B            (B),
        .Sub          (Sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .Sum_reg      (Sum_reg),
        .Carry_reg    (Carry_reg),
        .Overflow_reg (Overflow_reg)
    );

    // Parameter sweep instances
    localparam int NSW = 4;
    localparam int SW_W [NSW] = '{2, 8, 16, 32};
    localparam int SW_S [NSW] = '{1, 4, 1, 8};
    localparam int SW_N = 1000;

    logic [NSW-1:0] sw_in_valid, sw_in_ready, sw_sub, sw_out_valid, sw_out_ready, sw_carry, sw_ovf;
    logic [31:0]    sw_a [NSW];
    logic [31:0]    sw_b [NSW];
    logic [1:0]     s0_sum;
    logic [7:0]     s1_sum;
    logic [15:0]    s2_sum;
    logic [31:0]    s3_sum;

    adder_pipelined #(.WIDTH(2), .STAGES(1)) u_sw0 (
        .Clk(Clk), .Rst(Rst), .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
        .A(sw_a[0][1:0]), .B(sw_b[0][1:0]), .Sub(sw_sub[0]), .out_valid(sw_out_valid[0]),
        .out_ready(sw_out_ready[0]), .Sum_reg(s0_sum), .Carry_reg(sw_carry[0]), .Overflow_reg(sw_ovf[0]));
    adder_pipelined #(.WIDTH(8), .STAGES(4)) u_sw1 (
        .Clk(Clk), .Rst(Rst), .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
        .A(sw_a[1][7:0]), .B(sw_b[1][7:0]), .Sub(sw_sub[1]), .out_valid(sw_out_valid[1]),
        .out_ready(sw_out_ready[1]), .Sum_reg(s1_sum), .Carry_reg(sw_carry[1]), .Overflow_reg(sw_ovf[1]));
    adder_pipelined #(.WIDTH(16), .STAGES(1)) u_sw2 (
        .Clk(Clk), .Rst(Rst), .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
        .A(sw_a[2][15:0]), .B(sw_b[2][15:0]), .Sub(sw_sub[2]), .out_valid(sw_out_valid[2]),
        .out_ready(sw_out_ready[2]), .Sum_reg(s2_sum), .Carry_reg(sw_carry[2]), .Overflow_reg(sw_ovf[2]));
    adder_pipelined #(.WIDTH(32), .STAGES(8)) u_sw3 (
        .Clk(Clk), .Rst(Rst), .in_valid(sw_in_valid[3]), .in_ready(sw_in_ready[3]),
        .A(sw_a[3]), .B(sw_b[3]), .Sub(sw_sub[3]), .out_valid(sw_out_valid[3]),
        .out_ready(sw_out_ready[3]), .Sum_reg(s3_sum), .Carry_reg(sw_carry[3]), .Overflow_reg(sw_ovf[3]));

    typedef struct packed {
        logic [33:0] res;     // {overflow, carry, sum}
        int          edge_n;  // clock edge that accepted the operands
        int          stalls;  // stalled edges seen up to acceptance
    } txn_t;

    txn_t sw_q [NSW][$];

    // Reference model: exact integer arithmetic on the unsigned and signed
    // readings of the operands, then reduced to WIDTH bits.
    function automatic logic [33:0] ref_result(input int w, input logic [31:0] a,
                                               input logic [31:0] b, input logic sub);
        longint m, ua, ub, sa, sb, r, sr;
        logic   c, v;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sub) begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub;
            c  = (r >= m);
            sr = sa + sb;
        end
        r = ((r % m) + m) % m;
        v = (sr < -(m / 2)) || (sr >= m / 2);
        return {v, c, 32'(r)};
    endfunction

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] sw_sum(input int i);
        case (i)
            0:       return {30'b0, s0_sum};
            1:       return {24'b0, s1_sum};
            2:       return {16'b0, s2_sum};
            default: return s3_sum;
        endcase
    endfunction

    // Offers one transaction to an idle pipe with out_ready=1 and reports the
    // result plus the number of rising edges from the accepting edge
    // (counted as 1) through the edge that raised out_valid.
    task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic sub,
                            output logic [7:0] s, output logic c, output logic v, output int edges);
        A = a; B = b; Sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge Clk);
        edges = 1;
        #1 in_valid = 1'b0;
        while (edges < 20) begin
            @(negedge Clk);
            if (out_valid) break;
            @(posedge Clk);
            edges++;
        end
        s = Sum_reg; c = Carry_reg; v = Overflow_reg;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        #2;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if ({Overflow_reg, Carry_reg, Sum_reg} !== 10'h0)
            begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {Overflow_reg, Carry_reg, Sum_reg}); end
        @(posedge Clk);
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_latency_carry();
        logic [7:0] s; logic c, v; int e;
        send_one(8'h0F, 8'h01, 1'b0, s, c, v, e);
        n_checks++;
        if (e !== 3) begin n_fail++; $display("FAIL latency: got %0d edges expected 3", e); end
        n_checks++;
        if ({v, c, s} !== {1'b0, 1'b0, 8'h10})
            begin n_fail++; $display("FAIL slice_carry_0F_01: got v=%b c=%b s=%h expected v=0 c=0 s=10", v, c, s); end
    endtask

    task automatic test_overflow();
        logic [7:0] s; logic c, v; int e;
        send_one(8'hFF, 8'h01, 1'b0, s, c, v, e);
        n_checks++;
        if ({v, c, s} !== {1'b0, 1'b1, 8'h00})
            begin n_fail++; $display("FAIL unsigned_ovf_FF_01: got v=%b c=%b s=%h expected v=0 c=1 s=00", v, c, s); end
        send_one(8'h7F, 8'h01, 1'b0, s, c, v, e);
        n_checks++;
        if ({v, c, s} !== {1'b1, 1'b0, 8'h80})
            begin n_fail++; $display("FAIL signed_ovf_7F_01: got v=%b c=%b s=%h expected v=1 c=0 s=80", v, c, s); end
    endtask

    task automatic test_subtract();
        logic [7:0] s; logic c, v; int e;
        send_one(8'h05, 8'h07, 1'b1, s, c, v, e);
        n_checks++;
        if ({v, c, s} !== {1'b0, 1'b0, 8'hFE})
            begin n_fail++; $display("FAIL sub_05_07: got v=%b c=%b s=%h expected v=0 c=0 s=FE", v, c, s); end
        send_one(8'h80, 8'h01, 1'b1, s, c, v, e);
        n_checks++;
        if ({v, c, s} !== {1'b1, 1'b1, 8'h7F})
            begin n_fail++; $display("FAIL sub_80_01: got v=%b c=%b s=%h expected v=1 c=1 s=7F", v, c, s); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b1;
        A = 8'h11; B = 8'h22; Sub = 1'b0; in_valid = 1'b1;
        @(posedge Clk);
        #1 A = 8'h33; B = 8'h44;
        @(posedge Clk);
        #1 A = 8'h55; B = 8'h66;
        #2 Rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00)
            begin n_fail++; $display("FAIL midreset_valid_ready: got %b expected 00", {out_valid, in_ready}); end
        n_checks++;
        if ({Overflow_reg, Carry_reg, Sum_reg} !== 10'h0)
            begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", {Overflow_reg, Carry_reg, Sum_reg}); end
        in_valid = 1'b0;
        @(posedge Clk);
        #3 Rst = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_result: got %0d results expected 0", seen); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [9:0]  exp_q [$];
        logic [9:0]  held, obs, exp_v;
        logic [33:0] r;
        bit          prev_stall = 0, acc;
        int          sent = 1, got = 0, c = 0, stall_seen = 0, extra = 0;
        A = 8'($urandom); B = 8'($urandom); Sub = 1'($urandom_range(1)); in_valid = 1'b1;
        while (c < 40 && got < 6) begin
            out_ready = !(c >= 4 && c <= 8);
            @(negedge Clk);
            acc = in_valid && in_ready;
            obs = {Overflow_reg, Carry_reg, Sum_reg};
            if (out_valid && !out_ready) begin
                stall_seen++;
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0 at cycle %0d", in_ready, c); end
                if (prev_stall) begin
                    n_checks++;
                    if (obs !== held) begin n_fail++; $display("FAIL bp_hold: got %h expected %h at cycle %0d", obs, held, c); end
                end
                held = obs;
                prev_stall = 1;
            end else begin
                prev_stall = 0;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_spurious: got result %h expected none", obs);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (obs !== exp_v) begin n_fail++; $display("FAIL bp_result%0d: got %h expected %h", got, obs, exp_v); end
                end
                got++;
            end
            if (acc) begin
                r = ref_result(8, {24'b0, A}, {24'b0, B}, Sub);
                exp_q.push_back({r[33], r[32], r[7:0]});
            end
            @(posedge Clk);
            c++;
            #1;
            if (acc) begin
                if (sent < 6) begin
                    A = 8'($urandom); B = 8'($urandom); Sub = 1'($urandom_range(1)); sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b1;
        n_checks++;
        if (got !== 6) begin n_fail++; $display("FAIL bp_count: got %0d results expected 6", got); end
        n_checks++;
        if (stall_seen !== 5) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall_seen); end
        repeat (6) begin
            @(negedge Clk);
            if (out_valid) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL bp_duplicate: got %0d extra results expected 0", extra); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_sweep();
        int   issued [NSW], popped [NSW], stall_cnt [NSW];
        bit   front_seen [NSW], acc [NSW], stl [NSW];
        int   edge_no = 0, cyc = 0, lat;
        bit   all_done = 0;
        txn_t t;
        for (int i = 0; i < NSW; i++) begin
            issued[i] = 0; popped[i] = 0; stall_cnt[i] = 0; front_seen[i] = 0;
        end
        sw_in_valid = '0;
        sw_out_ready = '1;
        while (cyc < 8000 && !all_done) begin
            @(negedge Clk);
            for (int i = 0; i < NSW; i++) begin
                acc[i] = sw_in_valid[i] && sw_in_ready[i];
                stl[i] = sw_out_valid[i] && !sw_out_ready[i];
                if (sw_out_valid[i]) begin
                    if (sw_q[i].size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL sweep%0d_spurious: got result %h expected none", i, sw_sum(i));
                    end else begin
                        t = sw_q[i][0];
                        if (!front_seen[i]) begin
                            // Edges from acceptance to arrival, with frozen
                            // (stalled) edges discounted.
                            lat = edge_no - t.edge_n - (stall_cnt[i] - t.stalls) + 1;
                            n_checks++;
                            if (lat !== SW_S[i] + 1)
                                begin n_fail++; $display("FAIL sweep%0d_latency: got %0d expected %0d", i, lat, SW_S[i] + 1); end
                            front_seen[i] = 1;
                        end
                        if (sw_out_ready[i]) begin
                            n_checks++;
                            if ({sw_ovf[i], sw_carry[i], sw_sum(i)} !== t.res)
                                begin n_fail++; $display("FAIL sweep%0d_result%0d: got %h expected %h", i, popped[i],
                                                         {sw_ovf[i], sw_carry[i], sw_sum(i)}, t.res); end
                            void'(sw_q[i].pop_front());
                            popped[i]++;
                            front_seen[i] = 0;
                        end
                    end
                end
            end
            @(posedge Clk);
            edge_no++;
            for (int i = 0; i < NSW; i++) begin
                if (stl[i]) stall_cnt[i]++;
                if (acc[i]) begin
                    t.res    = ref_result(SW_W[i], sw_a[i], sw_b[i], sw_sub[i]);
                    t.edge_n = edge_no;
                    t.stalls = stall_cnt[i];
                    sw_q[i].push_back(t);
                end
            end
            #1;
            all_done = 1;
            for (int i = 0; i < NSW; i++) begin
                if (!sw_in_valid[i] || acc[i]) begin
                    if (issued[i] < SW_N && $urandom_range(3) != 0) begin
                        sw_in_valid[i] = 1'b1;
                        sw_a[i] = $urandom() & wmask(SW_W[i]);
                        sw_b[i] = $urandom() & wmask(SW_W[i]);
                        sw_sub[i] = 1'($urandom_range(1));
                        issued[i]++;
                    end else begin
                        sw_in_valid[i] = 1'b0;
                    end
                end
                sw_out_ready[i] = ($urandom_range(3) != 0);
                if (popped[i] < SW_N) all_done = 0;
            end
            cyc++;
        end
        for (int i = 0; i < NSW; i++) begin
            n_checks++;
            if (popped[i] !== SW_N || sw_q[i].size() !== 0)
                begin n_fail++; $display("FAIL sweep%0d_drain: got %0d results (%0d pending) expected %0d", i, popped[i], sw_q[i].size(), SW_N); end
        end
        sw_in_valid = '0;
    endtask

    initial begin
        Rst = 1'b1;
        in_valid = 1'b0; A = '0; B = '0; Sub = 1'b0; out_ready = 1'b1;
        sw_in_valid = '0; sw_out_ready = '1; sw_sub = '0;
        for (int i = 0; i < NSW; i++) begin
            sw_a[i] = '0;
            sw_b[i] = '0;
        end
        test_reset();
        test_latency_carry();
        test_overflow();
        test_subtract();
        test_reset_mid();
        test_backpressure();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_pipelined.md
Name: adder_pipelined

Overview:
- Parametrised, registered two's-complement add/subtract unit: the next generation of the team's registered ripple-carry adder.
- Operand width and pipeline depth are configurable. Add/subtract is selectable per transaction.
- Valid/ready handshakes on input and output support backpressure.
- Used as the arithmetic datapath stage between operand-source logic and downstream result consumers.

Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥2.
- STAGES, 2: number of carry-split adder stages. Each stage adds a WIDTH/STAGES-bit slice. WIDTH % STAGES must be 0. Illegal values halt elaboration via $error.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand transaction offered.
- in_ready  output  1  block can accept an operand this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sub  input  1  0 = A+B, 1 = A−B; sampled with the operands.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- Sum_reg  output  WIDTH  registered result.
- Carry_reg  output  1  registered carry-out of the MSB. For Sub it is the not-borrow bit: 1 when A ≥ B unsigned.
- Overflow_reg  output  1  registered signed-overflow flag.

Behaviour:
- Reset is asynchronous and active-high; clock is Clk.
  - While Rst=1, every pipeline valid bit, Sum_reg, Carry_reg and Overflow_reg are 0, and out_valid=0.
  - in_ready=0 while Rst is asserted; it returns to 1 on the first cycle after deassertion.
  - Reset mid-operation discards all in-flight transactions. No partial result ever appears.
- Structure: one input register stage (A, B, Sub, valid), then STAGES slice stages. The last slice stage is the output register.
- Slice k (k=0..STAGES−1) adds bits [k·S+S−1 : k·S], where S = WIDTH/STAGES.
  - Slice 0 carry-in is Sub. Slice k>0 carry-in is the registered carry from slice k−1.
  - The B slice is XORed with Sub before adding.
- Higher operand slices and lower completed sum slices travel alongside in skew registers. The final stage holds the full WIDTH-bit sum.
- Latency is STAGES+1 rising edges from input acceptance (in_valid && in_ready) to out_valid=1, with no stalls.
  - Example: STAGES=1 gives 2 cycles, matching the existing synchronous adder.
- Throughput is one transaction per cycle while out_ready=1.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall && !Rst.
  - When stall=1, all pipeline registers, including valid bits and bubbles, hold their values.
  - When stall=0, all stages advance by one; the input stage loads in_valid && in_ready.
  - Sum_reg, Carry_reg and Overflow_reg must stay stable while out_valid && !out_ready.
  - Bubbles (valid=0) advance normally, so out_valid may drop between results.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Overflow = carry into MSB XOR carry out of MSB, computed in the final slice.
  - Carry_reg = carry out of the MSB of the final slice.
- Boundary conditions:
  - A simultaneous output drain and input accept in the same cycle is legal and lossless.
  - in_valid while in_ready=0 is ignored. The source must hold its operands, per the valid/ready protocol.
  - Sub is captured per transaction, so mixed add/sub streams are legal back-to-back.
  - Data values are don't-care when their valid bit is 0, but must not be X after reset.

Decomposition:
- Package adder_pkg holds:
  - the handshake-stage valid/stall width constants;
  - a localparam function slice_width(WIDTH, STAGES);
  - the elaboration checks.
- Sub-module adder_slice is combinational and parametrised on S. It takes A slice, B slice, Sub and cin, and produces the sum slice, cout and cin-to-MSB for the overflow calculation. It is instantiated STAGES times via generate.

Test Plan:
- Reset mid-stream: WIDTH=8, STAGES=2. Issue 3 back-to-back adds, then assert Rst in cycle 2 → out_valid, Sum_reg, Carry_reg and Overflow_reg all 0 immediately (asynchronous), and no result appears after release.
- Latency and carry across a slice boundary: 0x0F+0x01, Sub=0 → out_valid exactly 3 edges after accept; Sum=0x10, Carry=0, Ovf=0.
- Unsigned and signed overflow: 0xFF+0x01 gives Sum=0x00, Carry=1, Ovf=0. 0x7F+0x01 gives Sum=0x80, Carry=0, Ovf=1.
- Subtract: 0x05−0x07 gives Sum=0xFE, Carry=0, Ovf=0. 0x80−0x01 gives Sum=0x7F, Carry=1, Ovf=1.
- Backpressure: stream 6 random transactions with out_ready=0 for cycles 4–8 → in_ready=0 during the stall, outputs stable, no loss or duplication, results in order against a scoreboard.
- Parameter sweep: (WIDTH,STAGES) ∈ {(2,1),(8,4),(16,1),(32,8)}, 1000 random add/sub transactions with random out_ready → every result matches the reference model, and latency equals STAGES+1 when unstalled.
